// File: rtl/execute_stage_p.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M register.
// Optional shift-add multiplier for OPq ifun 4 (mulq) is enabled by defining IMUL_EN.
module execute_stage_p #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             m_stall,
  input  logic             m_bubble,
  input  logic             cc_suppress,
  output logic             busy,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic [3:0]       M_ifun,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  logic [WIDTH-1:0] alu_val;
  logic             op_ok;
  logic             of_flag;
  logic             cnd_raw;
  logic             cnd;
  logic             load_en;
  logic             cc_we;
  logic [WIDTH-1:0] mul_acc_reg;

`ifdef IMUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

  mul_state_t       state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    count_reg;
  logic             mul_start;
  logic             mul_step;
  logic             is_mul;

  assign is_mul = e_valid && (e_icode == I_OPQ) && (e_ifun == 4'h4);

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_mul) begin
          busy = 1'b1;
          if (!m_stall) begin
            state_next = MUL;
            mul_start  = 1'b1;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (m_bubble) begin
          state_next = IDLE;
        end else begin
          mul_step = 1'b1;
          if (count_reg == CW'(WIDTH - 1)) state_next = DONE;
        end
      end
      DONE: begin
        // Result loads (or is killed by a bubble) on any unstalled edge.
        if (!m_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mul_acc_reg <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (mul_start) begin
        mul_acc_reg <= '0;
        mcand_reg   <= e_valB;
        mplier_reg  <= e_valA;
        count_reg   <= '0;
      end else if (mul_step) begin
        if (mplier_reg[0]) mul_acc_reg <= mul_acc_reg + mcand_reg;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
      end
    end
  end
`else
  assign busy        = 1'b0;
  assign mul_acc_reg = '0;
`endif

  always_comb begin
    alu_val = '0;
    op_ok   = 1'b0;
    case (e_icode)
      I_CMOV:           alu_val = e_valA;
      I_IRMOV:          alu_val = e_valC;
      I_RMMOV, I_MRMOV: alu_val = e_valB + e_valC;
      I_CALL, I_PUSH:   alu_val = e_valB - EIGHT;
      I_RET, I_POP:     alu_val = e_valB + EIGHT;
      I_OPQ: begin
        case (e_ifun)
          4'h0: begin alu_val = e_valB + e_valA; op_ok = 1'b1; end
          4'h1: begin alu_val = e_valB - e_valA; op_ok = 1'b1; end
          4'h2: begin alu_val = e_valB & e_valA; op_ok = 1'b1; end
          4'h3: begin alu_val = e_valB ^ e_valA; op_ok = 1'b1; end
`ifdef IMUL_EN
          4'h4: begin alu_val = mul_acc_reg;     op_ok = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    of_flag = 1'b0;
    if (e_ifun == 4'h0)
      of_flag = (e_valA[WIDTH-1] == e_valB[WIDTH-1]) && (alu_val[WIDTH-1] != e_valB[WIDTH-1]);
    else if (e_ifun == 4'h1)
      of_flag = (e_valA[WIDTH-1] != e_valB[WIDTH-1]) && (alu_val[WIDTH-1] != e_valB[WIDTH-1]);
  end

  // Conditions always use the CC value held before this edge's write.
  always_comb begin
    case (e_ifun)
      4'h0:    cnd_raw = 1'b1;
      4'h1:    cnd_raw = (cc_sf ^ cc_of) | cc_zf;
      4'h2:    cnd_raw = cc_sf ^ cc_of;
      4'h3:    cnd_raw = cc_zf;
      4'h4:    cnd_raw = !cc_zf;
      4'h5:    cnd_raw = !(cc_sf ^ cc_of);
      4'h6:    cnd_raw = !(cc_sf ^ cc_of) && !cc_zf;
      default: cnd_raw = 1'b0;
    endcase
  end

  assign cnd     = ((e_icode == I_JXX) || (e_icode == I_CMOV)) && cnd_raw;
  assign load_en = !m_stall && !m_bubble && e_valid && !busy;
  assign cc_we   = load_en && (e_icode == I_OPQ) && op_ok && !cc_suppress;

  always_ff @(posedge clk) begin
    if (rst) begin
      M_valid <= 1'b0;
      M_icode <= I_NOP;
      M_ifun  <= 4'h0;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (!m_stall) begin
      if (load_en) begin
        M_valid <= 1'b1;
        M_icode <= e_icode;
        M_ifun  <= e_ifun;
        M_cnd   <= cnd;
        M_valE  <= alu_val;
        M_valA  <= e_valA;
        M_dstE  <= (e_icode == I_CMOV && !cnd_raw) ? R_NONE : e_dstE;
        M_dstM  <= e_dstM;
      end else begin
        M_valid <= 1'b0;
        M_icode <= I_NOP;
        M_ifun  <= 4'h0;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= R_NONE;
        M_dstM  <= R_NONE;
      end
    end
  end

  // Multiply results never overflow in the flag sense: OF is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_we) begin
      cc_zf <= (alu_val == '0);
      cc_sf <= alu_val[WIDTH-1];
      cc_of <= (e_ifun == 4'h4) ? 1'b0 : of_flag;
    end
  end

endmodule

// File: tb/tb_execute_stage_p.sv
// Self-checking bench for execute_stage_p (WIDTH=64): vector table with a scoreboard
// queue, plus hand sequences for reset and the optional multiplier.
module tb_execute_stage_p;

  localparam int W = 64;
  localparam logic [3:0] F = 4'hF;

  logic         clk = 1'b0;
  logic         rst;
  logic         e_valid;
  logic [3:0]   e_icode, e_ifun, e_dstE, e_dstM;
  logic [W-1:0] e_valA, e_valB, e_valC;
  logic         m_stall, m_bubble, cc_suppress;
  logic         busy, M_valid, M_cnd, cc_zf, cc_sf, cc_of;
  logic [3:0]   M_icode, M_ifun, M_dstE, M_dstM;
  logic [W-1:0] M_valE, M_valA;

  int n_cmp = 0;
  int n_bad = 0;

  execute_stage_p #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .m_stall(m_stall), .m_bubble(m_bubble), .cc_suppress(cc_suppress), .busy(busy),
    .M_valid(M_valid), .M_icode(M_icode), .M_ifun(M_ifun), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         v;
    logic [3:0]   ic, fn;
    logic [W-1:0] a, b, c;
    logic [3:0]   de, dm;
    logic         st, bb, sp;
    logic         x_valid;
    logic [3:0]   x_icode;
    logic         x_cnd;
    logic [W-1:0] x_vale, x_vala;
    logic [3:0]   x_dste, x_dstm;
    logic [2:0]   x_cc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic v, logic [3:0] ic, logic [3:0] fn,
                              logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                              logic [3:0] de, logic [3:0] dm, logic st, logic bb, logic sp,
                              logic xv, logic [3:0] xic, logic xcnd, logic [W-1:0] xve,
                              logic [W-1:0] xva, logic [3:0] xde, logic [3:0] xdm,
                              logic [2:0] xcc);
    vec_t r;
    r.name = name; r.v = v; r.ic = ic; r.fn = fn; r.a = a; r.b = b; r.c = c;
    r.de = de; r.dm = dm; r.st = st; r.bb = bb; r.sp = sp;
    r.x_valid = xv; r.x_icode = xic; r.x_cnd = xcnd; r.x_vale = xve; r.x_vala = xva;
    r.x_dste = xde; r.x_dstm = xdm; r.x_cc = xcc;
    return r;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    e_valid = t.v; e_icode = t.ic; e_ifun = t.fn;
    e_valA = t.a; e_valB = t.b; e_valC = t.c;
    e_dstE = t.de; e_dstM = t.dm;
    m_stall = t.st; m_bubble = t.bb; cc_suppress = t.sp;
  endtask

  task automatic idle_inputs();
    e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0;
    e_valA = '0; e_valB = '0; e_valC = '0; e_dstE = F; e_dstM = F;
    m_stall = 1'b0; m_bubble = 1'b0; cc_suppress = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] MAXP, MINN, ALL1;
    int cycles;
    vec_t t;
    MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    MINN = 64'h8000_0000_0000_0000;
    ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    //         name        v ic fn a       b       c      de dm st bb sp | xv xic cnd xvale   xvala  xde xdm cc(ZSO)
    vecs.push_back(mk("subq_eq",   1,6,1, 1,     1,     0,    2,F,0,0,0, 1,6,0, 0,      1,     2,F,3'b100));
    vecs.push_back(mk("addq_of",   1,6,0, 1,     MAXP,  0,    2,F,0,0,0, 1,6,0, MINN,   1,     2,F,3'b011));
    vecs.push_back(mk("subq_neg",  1,6,1, 1,     0,     0,    2,F,0,0,0, 1,6,0, ALL1,   1,     2,F,3'b010));
    vecs.push_back(mk("jl",        1,7,2, 0,     0,     'h40, F,F,0,0,0, 1,7,1, 0,      0,     F,F,3'b010));
    vecs.push_back(mk("jge",       1,7,5, 0,     0,     'h40, F,F,0,0,0, 1,7,0, 0,      0,     F,F,3'b010));
    vecs.push_back(mk("cmovle",    1,2,1, 'h55,  0,     0,    3,F,0,0,0, 1,2,1, 'h55,   'h55,  3,F,3'b010));
    vecs.push_back(mk("cmovg",     1,2,6, 'h55,  0,     0,    3,F,0,0,0, 1,2,0, 'h55,   'h55,  F,F,3'b010));
    vecs.push_back(mk("stall_add", 1,6,0, 1,     1,     0,    2,F,1,0,0, 1,2,0, 'h55,   'h55,  F,F,3'b010));
    vecs.push_back(mk("subq_supp", 1,6,1, 5,     5,     0,    4,F,0,0,1, 1,6,0, 0,      5,     4,F,3'b010));
    vecs.push_back(mk("stall_bub", 1,6,0, 1,     2,     0,    2,F,1,1,0, 1,6,0, 0,      5,     4,F,3'b010));
    vecs.push_back(mk("bubble",    1,6,0, 1,     2,     0,    2,F,0,1,0, 0,1,0, 0,      0,     F,F,3'b010));
    vecs.push_back(mk("invalid",   0,6,0, 1,     2,     0,    2,F,0,0,0, 0,1,0, 0,      0,     F,F,3'b010));
    vecs.push_back(mk("pushq",     1,'hA,0,'h77, 'h100, 0,    4,F,0,0,0, 1,'hA,0,'hF8,  'h77,  4,F,3'b010));
    vecs.push_back(mk("popq",      1,'hB,0,0,    'h100, 0,    4,5,0,0,0, 1,'hB,0,'h108, 0,     4,5,3'b010));
    vecs.push_back(mk("call",      1,8,0, 0,     'h100, 'h200,4,F,0,0,0, 1,8,0, 'hF8,   0,     4,F,3'b010));
    vecs.push_back(mk("ret",       1,9,0, 0,     'h100, 0,    4,F,0,0,0, 1,9,0, 'h108,  0,     4,F,3'b010));
    vecs.push_back(mk("rmmovq",    1,4,0, 'h33,  'h100, 8,    F,F,0,0,0, 1,4,0, 'h108,  'h33,  F,F,3'b010));
    vecs.push_back(mk("mrmovq",    1,5,0, 0,     'h100, 8,    F,6,0,0,0, 1,5,0, 'h108,  0,     F,6,3'b010));
    vecs.push_back(mk("irmovq",    1,3,0, 0,     'h999, 'h2A, 7,F,0,0,0, 1,3,0, 'h2A,   0,     7,F,3'b010));
    vecs.push_back(mk("xorq",      1,6,3, 'hF0,  'hFF,  0,    2,F,0,0,0, 1,6,0, 'h0F,   'hF0,  2,F,3'b000));
    vecs.push_back(mk("andq_zero", 1,6,2, 'hF0,  'h0F,  0,    2,F,0,0,0, 1,6,0, 0,      'hF0,  2,F,3'b100));
    vecs.push_back(mk("opq_bad",   1,6,7, 1,     2,     0,    2,F,0,0,0, 1,6,0, 0,      1,     2,F,3'b100));
    vecs.push_back(mk("jmp",       1,7,0, 0,     0,     0,    F,F,0,0,0, 1,7,1, 0,      0,     F,F,3'b100));
    vecs.push_back(mk("j_bad",     1,7,7, 0,     0,     0,    F,F,0,0,0, 1,7,0, 0,      0,     F,F,3'b100));
    vecs.push_back(mk("cmove",     1,2,3, 9,     0,     0,    3,F,0,0,0, 1,2,1, 9,      9,     3,F,3'b100));
    vecs.push_back(mk("nop",       1,1,0, 0,     0,     0,    F,F,0,0,0, 1,1,0, 0,      0,     F,F,3'b100));
    vecs.push_back(mk("addq_nof",  1,6,0, MINN,  MINN,  0,    2,F,0,0,0, 1,6,0, 0,      MINN,  2,F,3'b101));
    vecs.push_back(mk("subq_of",   1,6,1, 1,     MINN,  0,    2,F,0,0,0, 1,6,0, MAXP,   1,     2,F,3'b001));
    vecs.push_back(mk("jle",       1,7,1, 0,     0,     0,    F,F,0,0,0, 1,7,1, 0,      0,     F,F,3'b001));
    vecs.push_back(mk("jg",        1,7,6, 0,     0,     0,    F,F,0,0,0, 1,7,0, 0,      0,     F,F,3'b001));
    vecs.push_back(mk("cmovne",    1,2,4, 7,     0,     0,    3,F,0,0,0, 1,2,1, 7,      7,     3,F,3'b001));

    // Reset sequence
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_M_valid", W'(M_valid), 0);
    chk("rst_M_icode", W'(M_icode), 1);
    chk("rst_M_ifun",  W'(M_ifun), 0);
    chk("rst_M_valE",  M_valE, 0);
    chk("rst_M_dstE",  W'(M_dstE), W'(F));
    chk("rst_M_dstM",  W'(M_dstM), W'(F));
    chk("rst_cc",      W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
    chk("rst_busy",    W'(busy), 0);
    $display("txn reset: M_valid=%0d cc=%b busy=%0d", M_valid, {cc_zf, cc_sf, cc_of}, busy);
    rst = 1'b0;

    // Vector table through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      #1;
      chk($sformatf("%s_busy", vecs[i].name), W'(busy), 0);
      @(posedge clk);
      #1;
      t = sb.pop_front();
      chk($sformatf("%s_valid", t.name), W'(M_valid), W'(t.x_valid));
      chk($sformatf("%s_icode", t.name), W'(M_icode), W'(t.x_icode));
      chk($sformatf("%s_cnd",   t.name), W'(M_cnd),   W'(t.x_cnd));
      chk($sformatf("%s_valE",  t.name), M_valE,      t.x_vale);
      chk($sformatf("%s_valA",  t.name), M_valA,      t.x_vala);
      chk($sformatf("%s_dstE",  t.name), W'(M_dstE),  W'(t.x_dste));
      chk($sformatf("%s_dstM",  t.name), W'(M_dstM),  W'(t.x_dstm));
      chk($sformatf("%s_cc",    t.name), W'({cc_zf, cc_sf, cc_of}), W'(t.x_cc));
      $display("txn %0d %s: valid=%0d icode=%h cnd=%0d valE=%h dstE=%h cc=%b",
               i, t.name, M_valid, M_icode, M_cnd, M_valE, M_dstE, {cc_zf, cc_sf, cc_of});
    end

`ifdef IMUL_EN
    // mulq 5*3: busy for WIDTH+1 cycles, then the result loads
    idle_inputs();
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h4; e_valA = 3; e_valB = 5; e_dstE = 4'h2;
    #1;
    chk("mul_busy_start", W'(busy), 1);
    cycles = 0;
    while (busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) chk("mul_M_bubble_while_busy", W'(M_valid), 0);
    end
    chk("mul_busy_cycles", W'(cycles), 65);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("mul_M_valid", W'(M_valid), 1);
    chk("mul_M_valE",  M_valE, 15);
    chk("mul_cc",      W'({cc_zf, cc_sf, cc_of}), W'(3'b000));
    $display("txn mulq: cycles=%0d valE=%h cc=%b", cycles, M_valE, {cc_zf, cc_sf, cc_of});

    // Reset in the middle of a multiply
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h4; e_valA = 3; e_valB = 5; e_dstE = 4'h2;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    e_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mulrst_busy",    W'(busy), 0);
    chk("mulrst_M_valid", W'(M_valid), 0);
    rst = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("mulrst_no_late_load", W'(M_valid), 0);
    chk("mulrst_busy_late",    W'(busy), 0);
    $display("txn mulq_reset: busy=%0d M_valid=%0d", busy, M_valid);
`else
    // ifun 4 is undefined without the multiplier: zero result, no CC write, never busy
    idle_inputs();
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h4; e_valA = 3; e_valB = 5; e_dstE = 4'h2;
    #1;
    chk("mul_off_busy", W'(busy), 0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("mul_off_valid", W'(M_valid), 1);
    chk("mul_off_valE",  M_valE, 0);
    chk("mul_off_cc",    W'({cc_zf, cc_sf, cc_of}), W'(3'b001));
    $display("txn mulq_disabled: valE=%h cc=%b", M_valE, {cc_zf, cc_sf, cc_of});
`endif

    // Reset after activity returns M and CC to their reset values
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h1; e_valA = 2; e_valB = 1; e_dstE = 4'h2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    chk("rst2_M_valid", W'(M_valid), 0);
    chk("rst2_cc",      W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
    $display("txn reset2: M_valid=%0d cc=%b", M_valid, {cc_zf, cc_sf, cc_of});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
